mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Single-port, byte-strobed memory model that answers the memory-side request/response interface driven by dm_cache.
- Port names match the cache's memory-side ports, so the two connect by name.
- Holds one request at a time, with programmable read and write latency.
- Used as a synthesizable backing store in cache test benches and FPGA bring-up builds.

Parameters:
- ADDR_W, default `ADDRESS_WIDTH (32): request address width in bits.
- DATA_W, default `WRITE_DATA (32): data word width in bits.
- STRB_W, default `WRITE_STROBE (4): byte-strobe width; must equal DATA_W/8.
- DEPTH_LOG2, default 10: log2 of the number of storage words (1024).
- RD_LATENCY, default 2: edges from read accept to o_mem_read_valid; legal range 1..15.
- WR_LATENCY, default 1: busy cycles after a write accept; legal range 1..15.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_mem_valid  in  1  request valid.
- i_mem_rd_wr  in  1  request type: 0 = read, 1 = write.
- i_mem_address  in  ADDR_W  byte address.
- o_mem_ready  out  1  request may be accepted.
- i_mem_write_data  in  DATA_W  write data.
- i_mem_write_strobe  in  STRB_W  byte enables; bit k enables data[8k+7:8k].
- o_mem_read_data  out  DATA_W  read response data.
- o_mem_read_valid  out  1  read response valid.
- i_mem_read_ready  in  1  consumer accepts the read response.

Behaviour:
- All outputs are registered.
- Reset values: o_mem_ready=0, o_mem_read_valid=0, o_mem_read_data=0, FSM=IDLE, latency counter=0.
- Storage array is NOT cleared by reset; contents survive a reset.
- Word index = i_mem_address[DEPTH_LOG2+1:2].
  - Byte-offset bits [1:0] are ignored.
  - Address bits above DEPTH_LOG2+1 are ignored, so addresses alias modulo 4*2^DEPTH_LOG2 bytes.
- Accept: at an edge where i_mem_valid && o_mem_ready, in IDLE only. All request fields are sampled at that edge.
- FSM states:
  - IDLE: o_mem_ready=1.
    - Accepted write -> WR_BUSY, counter loads WR_LATENCY-1.
    - Accepted read -> RD_WAIT, counter loads RD_LATENCY-1.
  - WR_BUSY: o_mem_ready=0.
    - counter==0 -> IDLE; otherwise decrement.
  - RD_WAIT: o_mem_ready=0.
    - counter==0 -> RD_RESP: o_mem_read_valid=1, o_mem_read_data = addressed word; otherwise decrement.
  - RD_RESP: o_mem_ready=0; o_mem_read_valid and o_mem_read_data held stable until i_mem_read_ready=1 at an edge.
    - At that edge: o_mem_read_valid=0, o_mem_read_data keeps its last value, state -> IDLE.
- Write commit: strobed bytes are written at the accept edge; unstrobed bytes are unchanged.
- Write with strobe 0: full handshake and busy period, but no storage change.
- Timing: accept at edge E.
  - Read: o_mem_read_valid rises at edge E+RD_LATENCY.
  - Write: o_mem_ready returns high at edge E+WR_LATENCY.
- Throughput: at most one request per WR_LATENCY+1 cycles (write) or RD_LATENCY+1+backpressure cycles (read).
- Read-after-write to the same word returns the merged write data. Only one request is ever in flight, so no hazard logic is needed.
- i_mem_read_ready while not in RD_RESP: ignored.
- i_mem_valid while o_mem_ready=0: ignored. Requester must hold it; nothing is queued.
- i_rst_n low in any state (including RD_RESP with valid high): at that edge go to reset values and drop the pending response. A write already committed at its accept edge stays committed.
- Latency parameters outside 1..15: elaboration error via generate-time check.

Test Plan:
- Byte-strobe write and readback.
  - Stimulus: reset, write addr 0x0000_0010, data 0xDEADBEEF, strobe 0xF; then read 0x10.
  - Required: o_mem_ready low for 1 cycle after the write; o_mem_read_valid rises exactly 2 edges after the read accept with data 0xDEADBEEF.
- Partial strobe merge.
  - Stimulus: write 0x10 data 0x11223344 strobe 0x5; then read 0x10.
  - Required: read data 0xDE22BE44.
- Aliasing and ignored byte offset.
  - Stimulus: with DEPTH_LOG2=10, write 0x0000_1010 data 0xA5A5A5A5 strobe 0xF; then read 0x12.
  - Required: read data 0xA5A5A5A5.
- Response backpressure.
  - Stimulus: read 0x10 with i_mem_read_ready held 0 for 5 cycles, then 1.
  - Required: o_mem_read_valid and data stable all 5 cycles; valid drops and o_mem_ready rises at the accepting edge; a new i_mem_valid during the hold is not accepted.
- Reset mid-response.
  - Stimulus: assert i_rst_n=0 while in RD_RESP.
  - Required: next edge shows o_mem_read_valid=0, o_mem_ready=0; after release o_mem_ready=1 one edge later; re-read of 0x10 still returns 0xA5A5A5A5.
- Latency sweep.
  - Stimulus: RD_LATENCY=1 and 15, WR_LATENCY=15.
  - Required: valid at E+1 and E+15 respectively; o_mem_ready low for exactly 15 cycles after the write.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-request byte-strobed memory model with programmable read/write latency
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef WRITE_DATA
`define WRITE_DATA 32
`endif
`ifndef WRITE_STROBE
`define WRITE_STROBE 4
`endif

module mem_responder #(
    parameter int ADDR_W     = `ADDRESS_WIDTH,
    parameter int DATA_W     = `WRITE_DATA,
    parameter int STRB_W     = `WRITE_STROBE,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mem_valid,
    input  logic              i_mem_rd_wr,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic              o_mem_ready,
    input  logic [DATA_W-1:0] i_mem_write_data,
    input  logic [STRB_W-1:0] i_mem_write_strobe,
    output logic [DATA_W-1:0] o_mem_read_data,
    output logic              o_mem_read_valid,
    input  logic              i_mem_read_ready
);

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_rd_latency
            $error("mem_responder: RD_LATENCY must be in 1..15");
        end
        if (WR_LATENCY < 1 || WR_LATENCY > 15) begin : g_bad_wr_latency
            $error("mem_responder: WR_LATENCY must be in 1..15");
        end
        if (STRB_W * 8 != DATA_W) begin : g_bad_strb
            $error("mem_responder: STRB_W must equal DATA_W/8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_WAIT = 2'd2,
        RD_RESP = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_next;
    logic                    w_load_rdata;
    logic                    w_accept;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic                    r_ready;
    logic                    r_rvalid;
    logic [DATA_W-1:0]       r_rdata;
    logic [DATA_W-1:0]       r_mem [0:(1<<DEPTH_LOG2)-1];
    logic                    w_unused;

    // Byte offset and bits above the array size are dropped, so addresses alias.
    assign w_idx    = i_mem_address[DEPTH_LOG2+1:2];
    assign w_unused = ^{i_mem_address[ADDR_W-1:DEPTH_LOG2+2], i_mem_address[1:0]};
    assign w_accept = i_mem_valid && r_ready && (r_state == IDLE);

    assign o_mem_ready      = r_ready;
    assign o_mem_read_valid = r_rvalid;
    assign o_mem_read_data  = r_rdata;

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_load_rdata = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (i_mem_rd_wr) begin
                        w_next_state = WR_BUSY;
                        w_cnt_next   = 4'(WR_LATENCY - 1);
                    end else begin
                        w_next_state = RD_WAIT;
                        w_cnt_next   = 4'(RD_LATENCY - 1);
                    end
                end
            end
            WR_BUSY: begin
                if (r_cnt == 4'd0) w_next_state = IDLE;
                else               w_cnt_next   = r_cnt - 4'd1;
            end
            RD_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = RD_RESP;
                    w_load_rdata = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RD_RESP: begin
                if (i_mem_read_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_ready  <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_idx    <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            // Ready is a registered copy of "next cycle is IDLE", so it rises one edge after reset release.
            r_ready <= (w_next_state == IDLE);
            if (w_accept) r_idx <= w_idx;
            if (w_load_rdata) begin
                r_rvalid <= 1'b1;
                r_rdata  <= r_mem[r_idx];
            end else if (r_state == RD_RESP && i_mem_read_ready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Storage has no reset; writes commit at the accept edge.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_accept && i_mem_rd_wr) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (i_mem_write_strobe[k]) r_mem[w_idx][8*k +: 8] <= i_mem_write_data[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        rready;
    logic        v   [3];
    logic        rdy [3];
    logic        rv  [3];
    logic [31:0] rd  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mem_valid(v[0]), .i_mem_rd_wr(rd_wr),
        .i_mem_address(addr), .o_mem_ready(rdy[0]), .i_mem_write_data(wdata),
        .i_mem_write_strobe(strb), .o_mem_read_data(rd[0]), .o_mem_read_valid(rv[0]),
        .i_mem_read_ready(rready)
    );

    mem_responder #(.RD_LATENCY(1), .WR_LATENCY(15)) u_dut_fast_rd (
        .i_clk(clk), .i_rst_n(rst_n), .i_mem_valid(v[1]), .i_mem_rd_wr(rd_wr),
        .i_mem_address(addr), .o_mem_ready(rdy[1]), .i_mem_write_data(wdata),
        .i_mem_write_strobe(strb), .o_mem_read_data(rd[1]), .o_mem_read_valid(rv[1]),
        .i_mem_read_ready(rready)
    );

    mem_responder #(.RD_LATENCY(15), .WR_LATENCY(1)) u_dut_slow_rd (
        .i_clk(clk), .i_rst_n(rst_n), .i_mem_valid(v[2]), .i_mem_rd_wr(rd_wr),
        .i_mem_address(addr), .o_mem_ready(rdy[2]), .i_mem_write_data(wdata),
        .i_mem_write_strobe(strb), .o_mem_read_data(rd[2]), .o_mem_read_valid(rv[2]),
        .i_mem_read_ready(rready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int lat, input string tag);
        v[w] = 1'b1; rd_wr = 1'b1; addr = a; wdata = d; strb = s;
        step();
        v[w] = 1'b0;
        chk({tag, "_ready_low"}, 32'(rdy[w]), 32'd0);
        for (int i = 1; i < lat; i++) begin
            step();
            chk({tag, "_ready_low"}, 32'(rdy[w]), 32'd0);
        end
        step();
        chk({tag, "_ready_back"}, 32'(rdy[w]), 32'd1);
    endtask

    task automatic do_read(input int w, input logic [31:0] a, input int lat,
                           input logic [31:0] exp, input int hold, input bit poke,
                           input string tag);
        v[w] = 1'b1; rd_wr = 1'b0; addr = a; rready = 1'b0;
        step();
        v[w] = 1'b0;
        chk({tag, "_valid_early"}, 32'(rv[w]), 32'd0);
        for (int i = 1; i < lat; i++) begin
            step();
            chk({tag, "_valid_early"}, 32'(rv[w]), 32'd0);
        end
        step();
        chk({tag, "_valid"}, 32'(rv[w]), 32'd1);
        chk({tag, "_data"}, rd[w], exp);
        if (poke) begin
            v[w] = 1'b1; rd_wr = 1'b1; addr = a; wdata = 32'h0; strb = 4'hF;
        end
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, "_hold_valid"}, 32'(rv[w]), 32'd1);
            chk({tag, "_hold_data"}, rd[w], exp);
            chk({tag, "_hold_ready"}, 32'(rdy[w]), 32'd0);
        end
        rready = 1'b1;
        step();
        v[w] = 1'b0; rready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(rv[w]), 32'd0);
        chk({tag, "_ready_rise"}, 32'(rdy[w]), 32'd1);
        chk({tag, "_data_kept"}, rd[w], exp);
    endtask

    initial begin
        rst_n = 1'b0; rd_wr = 1'b0; addr = '0; wdata = '0; strb = '0; rready = 1'b0;
        for (int i = 0; i < 3; i++) v[i] = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(rdy[0]), 32'd0);
        chk("rst_valid", 32'(rv[0]), 32'd0);
        chk("rst_data", rd[0], 32'd0);
        rst_n = 1'b1;
        step();
        chk("rel_ready0", 32'(rdy[0]), 32'd1);
        chk("rel_ready1", 32'(rdy[1]), 32'd1);
        chk("rel_ready2", 32'(rdy[2]), 32'd1);

        do_write(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1, "wr_full");
        do_read (0, 32'h0000_0010, 2, 32'hDEAD_BEEF, 0, 1'b0, "rd_full");
        do_write(0, 32'h0000_0010, 32'h1122_3344, 4'h5, 1, "wr_part");
        do_read (0, 32'h0000_0010, 2, 32'hDE22_BE44, 0, 1'b0, "rd_merge");
        do_write(0, 32'h0000_1010, 32'hA5A5_A5A5, 4'hF, 1, "wr_alias");
        do_read (0, 32'h0000_0012, 2, 32'hA5A5_A5A5, 0, 1'b0, "rd_alias");
        do_read (0, 32'h0000_0010, 2, 32'hA5A5_A5A5, 5, 1'b1, "rd_bp");
        do_write(0, 32'h0000_0010, 32'h0000_0000, 4'h0, 1, "wr_nostrb");

        // Reset while the response is pending.
        v[0] = 1'b1; rd_wr = 1'b0; addr = 32'h10; rready = 1'b0;
        step();
        v[0] = 1'b0;
        step();
        step();
        chk("pre_rst_valid", 32'(rv[0]), 32'd1);
        rst_n = 1'b0;
        step();
        chk("midrst_valid", 32'(rv[0]), 32'd0);
        chk("midrst_ready", 32'(rdy[0]), 32'd0);
        rst_n = 1'b1;
        step();
        chk("midrst_rel_ready", 32'(rdy[0]), 32'd1);
        do_read (0, 32'h0000_0010, 2, 32'hA5A5_A5A5, 1, 1'b0, "rd_after_rst");

        do_write(1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 15, "wr_lat15");
        do_read (1, 32'h0000_0040, 1, 32'hCAFE_F00D, 0, 1'b0, "rd_lat1");
        do_write(2, 32'h0000_0044, 32'h0BAD_C0DE, 4'hF, 1, "wr_lat1");
        do_read (2, 32'h0000_0044, 15, 32'h0BAD_C0DE, 0, 1'b0, "rd_lat15");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
